// File: rtl/gen_mod_counter.sv
// gen_mod_counter: parametrised up/down modulo counter with synchronous load,
// terminal-count pulse, one-shot mode (RUN/DONE) and an optional prescaler.
// Optional feature macro: COUNTER_PRESCALE_EN (adds the enabled-cycle prescaler).
module gen_mod_counter #(
  parameter int unsigned WIDTH   = 27,
  parameter int unsigned PRESC_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               up_dn,
  input  logic               oneshot,
  input  logic               load,
  input  logic [WIDTH-1:0]   load_val,
  input  logic [WIDTH-1:0]   modulo,
  input  logic [PRESC_W-1:0] prescale_div,
  output logic [WIDTH-1:0]   counter,
  output logic               tc,
  output logic               done
);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_nxt_state;
  logic [WIDTH-1:0]   r_cnt;
  logic [WIDTH-1:0]   w_nxt_cnt;
  logic               r_tc;
  logic               w_nxt_tc;
  logic               r_done;
  logic               w_nxt_done;
  logic               w_step;
  logic               w_wrap;

`ifdef COUNTER_PRESCALE_EN
  logic [PRESC_W-1:0] r_presc;
  logic [PRESC_W-1:0] w_nxt_presc;
  logic               w_expire;

  assign w_expire = (r_presc == prescale_div);
  assign w_step   = en & w_expire;

  // Prescaler next value: counts enabled cycles 0..prescale_div, holds while idle
  always_comb begin
    w_nxt_presc = r_presc;
    if (load) begin
      w_nxt_presc = '0;
    end else if (en) begin
      w_nxt_presc = w_expire ? '0 : r_presc + PRESC_W'(1);
    end
  end

  // Prescaler register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc <= '0;
    end else begin
      r_presc <= w_nxt_presc;
    end
  end
`else
  logic w_unused_presc;

  // Without the prescaler every enabled cycle is a step; the divider input is ignored
  assign w_unused_presc = ^prescale_div;
  assign w_step         = en;
`endif

  // Wrap condition also catches a count left above a lowered modulo
  assign w_wrap = up_dn ? (r_cnt >= modulo)
                        : ((r_cnt == '0) || (r_cnt > modulo));

  // Next-state / next-output logic: load > step > hold
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_cnt   = r_cnt;
    w_nxt_tc    = 1'b0;
    w_nxt_done  = r_done;
    if (load) begin
      w_nxt_cnt   = load_val;
      w_nxt_done  = 1'b0;
      w_nxt_state = ST_RUN;
    end else if (r_state == ST_DONE) begin
      // Leaving one-shot releases the counter; done stays set until a load
      if (!oneshot) begin
        w_nxt_state = ST_RUN;
      end
    end else if (w_step) begin
      if (w_wrap) begin
        w_nxt_tc = 1'b1;
        if (oneshot) begin
          w_nxt_done  = 1'b1;
          w_nxt_state = ST_DONE;
        end else begin
          w_nxt_cnt = up_dn ? '0 : modulo;
        end
      end else begin
        w_nxt_cnt = up_dn ? r_cnt + WIDTH'(1) : r_cnt - WIDTH'(1);
      end
    end
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_RUN;
      r_cnt   <= '0;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_nxt_state;
      r_cnt   <= w_nxt_cnt;
      r_tc    <= w_nxt_tc;
      r_done  <= w_nxt_done;
    end
  end

  assign counter = r_cnt;
  assign tc      = r_tc;
  assign done    = r_done;

endmodule

// File: tb/tb_gen_mod_counter.sv
// Directed self-checking bench for gen_mod_counter (WIDTH=8).
module tb_gen_mod_counter;

  localparam int unsigned W  = 8;
  localparam int unsigned PW = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en = 1'b0;
  logic          up_dn = 1'b1;
  logic          oneshot = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  load_val = '0;
  logic [W-1:0]  modulo = '0;
  logic [PW-1:0] prescale_div = '0;
  logic [W-1:0]  counter;
  logic          tc;
  logic          done;

  int n_vec = 0;
  int n_err = 0;

  gen_mod_counter #(.WIDTH(W), .PRESC_W(PW)) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .up_dn        (up_dn),
    .oneshot      (oneshot),
    .load         (load),
    .load_val     (load_val),
    .modulo       (modulo),
    .prescale_div (prescale_div),
    .counter      (counter),
    .tc           (tc),
    .done         (done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input int val, input int mod);
    load = 1'b1; load_val = W'(val); modulo = W'(mod);
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    n_vec++;
    if (counter !== 8'd0 || tc !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL reset: counter=%0d tc=%b done=%b expected 0/0/0", counter, tc, done);
    end
    tick();
    rst = 1'b0;
  endtask

  task automatic test_up_wrap();
    int exp_c;
    modulo = 8'd9; up_dn = 1'b1; en = 1'b1;
    for (int k = 0; k < 11; k++) begin
      tick();
      exp_c = (k + 1) % 10;
      n_vec++;
      if (counter !== W'(exp_c) || tc !== (exp_c == 0)) begin
        n_err++;
        $display("FAIL up_wrap step %0d: counter=%0d tc=%b expected %0d/%b",
                 k, counter, tc, exp_c, (exp_c == 0));
      end
    end
    en = 1'b0;
  endtask

  task automatic test_down();
    int exp_c[4] = '{1, 0, 5, 4};
    up_dn = 1'b0;
    do_load(2, 5);
    n_vec++;
    if (counter !== 8'd2 || tc !== 1'b0) begin
      n_err++;
      $display("FAIL down_load: counter=%0d tc=%b expected 2/0", counter, tc);
    end
    en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_vec++;
      if (counter !== W'(exp_c[k]) || tc !== (k == 2)) begin
        n_err++;
        $display("FAIL down step %0d: counter=%0d tc=%b expected %0d/%b",
                 k, counter, tc, exp_c[k], (k == 2));
      end
    end
    en = 1'b0;
    up_dn = 1'b1;
  endtask

  task automatic test_oneshot();
    int exp_c[6]   = '{1, 2, 3, 3, 3, 3};
    logic exp_t[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic exp_d[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
    oneshot = 1'b1; up_dn = 1'b1;
    do_load(0, 3);
    en = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      n_vec++;
      if (counter !== W'(exp_c[k]) || tc !== exp_t[k] || done !== exp_d[k]) begin
        n_err++;
        $display("FAIL oneshot step %0d: counter=%0d tc=%b done=%b expected %0d/%b/%b",
                 k, counter, tc, done, exp_c[k], exp_t[k], exp_d[k]);
      end
    end
    load = 1'b1; load_val = 8'd0;
    tick();
    load = 1'b0;
    n_vec++;
    if (counter !== 8'd0 || tc !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_reload: counter=%0d tc=%b done=%b expected 0/0/0", counter, tc, done);
    end
    tick();
    n_vec++;
    if (counter !== 8'd1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL oneshot_resume: counter=%0d done=%b expected 1/0", counter, done);
    end
    en = 1'b0;
    oneshot = 1'b0;
  endtask

  task automatic test_modulo_zero();
    do_load(0, 0);
    en = 1'b1;
    for (int k = 0; k < 3; k++) begin
      up_dn = (k < 2);
      tick();
      n_vec++;
      if (counter !== 8'd0 || tc !== 1'b1) begin
        n_err++;
        $display("FAIL modulo_zero step %0d: counter=%0d tc=%b expected 0/1", k, counter, tc);
      end
    end
    en = 1'b0;
    up_dn = 1'b1;
  endtask

  task automatic test_prescale();
`ifdef COUNTER_PRESCALE_EN
    int   exp_c[8] = '{0, 0, 1, 1, 1, 1, 1, 2};
    logic en_v[8]  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    prescale_div = 8'd2;
`else
    int   exp_c[8] = '{1, 2, 3, 3, 3, 4, 5, 6};
    logic en_v[8]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
`endif
    up_dn = 1'b1;
    do_load(0, 9);
    for (int k = 0; k < 8; k++) begin
      en = en_v[k];
      tick();
      n_vec++;
      if (counter !== W'(exp_c[k])) begin
        n_err++;
        $display("FAIL prescale step %0d: counter=%0d expected %0d", k, counter, exp_c[k]);
      end
    end
    en = 1'b0;
    prescale_div = 8'd0;
  endtask

  task automatic test_load_priority();
    do_load(7, 30);
    n_vec++;
    if (counter !== 8'd7) begin
      n_err++;
      $display("FAIL load_seed: counter=%0d expected 7", counter);
    end
    en = 1'b1; load = 1'b1; load_val = 8'd20;
    tick();
    load = 1'b0;
    n_vec++;
    if (counter !== 8'd20 || tc !== 1'b0) begin
      n_err++;
      $display("FAIL load_over_en: counter=%0d tc=%b expected 20/0", counter, tc);
    end
    modulo = 8'd4; up_dn = 1'b1;
    tick();
    n_vec++;
    if (counter !== 8'd0 || tc !== 1'b1) begin
      n_err++;
      $display("FAIL above_modulo: counter=%0d tc=%b expected 0/1", counter, tc);
    end
    en = 1'b0;
    tick();
    n_vec++;
    if (counter !== 8'd0 || tc !== 1'b0) begin
      n_err++;
      $display("FAIL hold_no_tc: counter=%0d tc=%b expected 0/0", counter, tc);
    end
  endtask

  task automatic test_async_reset();
    do_load(8'h55, 255);
    n_vec++;
    if (counter !== 8'h55) begin
      n_err++;
      $display("FAIL areset_seed: counter=%0h expected 55", counter);
    end
    #2 rst = 1'b1;
    #1;
    n_vec++;
    if (counter !== 8'd0 || tc !== 1'b0 || done !== 1'b0) begin
      n_err++;
      $display("FAIL areset_now: counter=%0d tc=%b done=%b expected 0/0/0", counter, tc, done);
    end
    rst = 1'b0;
    en = 1'b1; up_dn = 1'b1;
    tick();
    n_vec++;
    if (counter !== 8'd1) begin
      n_err++;
      $display("FAIL areset_restart: counter=%0d expected 1", counter);
    end
    en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down();
    test_oneshot();
    test_modulo_zero();
    test_prescale();
    test_load_priority();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
